sprite_ram_loader: RTL and testbench
====================================

// Module: sprite_ram_loader
// PURPOSE
//  CPU-side writer for the 128-byte sprite attribute RAM that the sprite engine reads each line.
//  CPU writes land in an internal shadow copy (32 sprites x 4 bytes), so the engine never sees a half-updated table.
//  On request, the whole shadow is copied into live sprite RAM during the next vblank, one byte per clock.
//  Also provides a bulk clear of the shadow.
//  Byte layout per sprite n at 4n..4n+3: {en,3'b0,Y[11:8]}, Y[7:0], {img[3:0],X[11:8]}, X[7:0].
// PARAMETERS
//  SPR_COUNT   32  number of sprites in the table
//  ITEM_WIDTH  4   bytes per sprite entry
//  ADDR_WIDTH  7   byte address width; must hold SPR_COUNT*ITEM_WIDTH-1
// PORTS
//  clk                input   1   system clock; everything runs on its rising edge
//  reset              input   1   asynchronous, active-low reset (0 = in reset)
//  vblank             input   1   vertical blank from the video timing block
//  cpu_addr           input   7   shadow byte address
//  cpu_din            input   8   CPU write data
//  cpu_wr             input   1   write strobe, one byte per cycle when high
//  cpu_rd             input   1   read strobe
//  cpu_dout           output  8   shadow read data, registered
//  commit_req         input   1   pulse: request a copy to live RAM at the next vblank rising edge
//  clear_req          input   1   pulse: zero the whole shadow
//  busy               output  1   high while a clear or copy is in progress
//  pending            output  1   high while a commit is armed but the copy has not started
//  committed          output  1   one-cycle pulse when a copy finishes
//  spriteram_wr_addr  output  7   live sprite RAM write address
//  spriteram_data_in  output  8   live sprite RAM write data
//  spriteram_wr       output  1   live sprite RAM write enable
// BEHAVIOUR
//  Reset values: cpu_dout=0, busy=0, pending=0, committed=0, spriteram_wr=0, spriteram_wr_addr=0, spriteram_data_in=0.
//    State=IDLE, vblank_last=0. Shadow contents are left undefined by reset.
//  CPU read: cpu_dout <= shadow[cpu_addr] on the cycle cpu_rd is high. Data is valid 1 cycle later; otherwise cpu_dout holds.
//  CPU write: shadow[cpu_addr] <= cpu_din. Accepted in every state except CLEAR; writes during CLEAR are dropped.
//  Same-cycle cpu_rd and cpu_wr to the same address return the old byte (read-before-write).
//  vblank rise = vblank & ~vblank_last, with vblank_last registered every cycle.
//  States:
//   IDLE:
//    - clear_req -> CLEAR. This has priority over commit_req in the same cycle; the commit is still armed (pending=1).
//    - else commit_req -> ARMED, pending=1.
//   ARMED:
//    - clear_req -> CLEAR, pending stays 1.
//    - vblank rise -> COPY, pending=0, busy=1, copy index=0.
//    - commit_req while ARMED has no effect. A commit armed while vblank is already high waits for the next rise.
//   CLEAR:
//    - busy=1; writes shadow[i]=0 for i=0..127, one per cycle (128 cycles).
//    - Then -> ARMED if pending=1, else -> IDLE.
//   COPY:
//    - Each cycle k=0..127 registers spriteram_wr=1, spriteram_wr_addr=k, spriteram_data_in=shadow[k].
//    - The first strobe is visible the cycle after the vblank rise is sampled; strobes are contiguous.
//    - After k=127: spriteram_wr=0, busy=0, committed=1 for one cycle, then -> IDLE, or -> ARMED if re-armed.
//    - A CPU write during COPY re-arms the commit (pending=1), so that byte is guaranteed to reach live RAM next frame.
//      The write itself takes effect in shadow immediately and is also copied this frame if its index is not yet copied.
//    - commit_req during COPY sets pending=1.
//    - clear_req during COPY is latched and serviced right after COPY, before the return to IDLE/ARMED.
//    - vblank falling mid-copy does not abort; the copy completes (128 cycles is far below vblank length).
//  Reset asserted mid-copy or mid-clear: abort immediately and go to reset values.
//    Live RAM may be partially updated; software must re-commit.
//  Address arithmetic: copy/clear index is ADDR_WIDTH bits and stops at 127; it never wraps to 0.
//    cpu_addr is used unmodified (no wrap checks needed at 7 bits).
//  spriteram_wr is never high outside COPY; the engine's read port is never stalled.
// TESTING
//  1. Write 0x81,0x10,0x23,0x40 to addr 0..3; read addr 2 -> cpu_dout=0x23 one cycle later. spriteram_wr stays 0 throughout.
//  2. commit_req with vblank low -> pending=1, no strobes. vblank rise -> 128 strobes, addr 0..127.
//     addr 0 data=0x81; committed pulses once; pending=0.
//  3. clear_req and commit_req in the same cycle -> busy for 128 cycles, shadow all 0.
//     Next vblank rise copies 128 zero bytes.
//  4. During COPY at k=10, write 0x55 to addr 5 -> live addr 5 keeps the old byte, pending=1.
//     Next vblank rise copies 0x55 to addr 5.
//  5. Pull reset low at copy k=64 -> spriteram_wr=0, busy=0, pending=0 within the same cycle (async).
//     After release the block stays IDLE through vblank.
//  6. commit_req while vblank already high -> no copy until vblank falls and rises again.

Source files
------------

// File: rtl/sprite_ram_loader_if.sv
// CPU-side and live-sprite-RAM signals of the sprite RAM loader, bundled as one bus.
// The master modport is the CPU/video side and the slave modport is the loader.
interface sprite_ram_loader_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  vblank;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [7:0]            cpu_din;
  logic                  cpu_wr;
  logic                  cpu_rd;
  logic [7:0]            cpu_dout;
  logic                  commit_req;
  logic                  clear_req;
  logic                  busy;
  logic                  pending;
  logic                  committed;
  logic [ADDR_WIDTH-1:0] spriteram_wr_addr;
  logic [7:0]            spriteram_data_in;
  logic                  spriteram_wr;

  modport master (
    output vblank, cpu_addr, cpu_din, cpu_wr, cpu_rd, commit_req, clear_req,
    input  cpu_dout, busy, pending, committed,
           spriteram_wr_addr, spriteram_data_in, spriteram_wr
  );

  modport slave (
    input  vblank, cpu_addr, cpu_din, cpu_wr, cpu_rd, commit_req, clear_req,
    output cpu_dout, busy, pending, committed,
           spriteram_wr_addr, spriteram_data_in, spriteram_wr
  );
endinterface

// File: rtl/sprite_ram_loader.sv
// Shadowed sprite attribute table: the CPU edits a private copy which is bulk-copied
// into live sprite RAM during vblank, one byte per clock, so the engine never sees a torn table.
module sprite_ram_loader #(
  parameter int SPR_COUNT  = 32,
  parameter int ITEM_WIDTH = 4,
  parameter int ADDR_WIDTH = 7
) (
  input logic                clk,
  input logic                reset,
  sprite_ram_loader_if.slave bus
);

  localparam int                    BYTES    = SPR_COUNT * ITEM_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CLEAR, COPY} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] idx, idx_next;
  logic                  pending_q, pending_next;
  logic                  clear_latch, clear_latch_next;
  logic                  vblank_last;
  logic                  vblank_rise;
  logic                  idx_last;
  logic                  committed_q;
  logic                  spr_wr_q;
  logic [ADDR_WIDTH-1:0] spr_addr_q;
  logic [7:0]            spr_data_q;
  logic [7:0]            cpu_dout_q;
  logic [7:0]            shadow [0:BYTES-1];

  assign vblank_rise = bus.vblank & ~vblank_last;
  assign idx_last    = (idx == LAST_IDX);

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    pending_next     = pending_q;
    clear_latch_next = clear_latch;
    case (state)
      IDLE: begin
        if (bus.clear_req) begin
          state_next = CLEAR;
          idx_next   = '0;
          if (bus.commit_req) pending_next = 1'b1;
        end else if (bus.commit_req) begin
          state_next   = ARMED;
          pending_next = 1'b1;
        end
      end
      ARMED: begin
        if (bus.clear_req) begin
          state_next = CLEAR;
          idx_next   = '0;
        end else if (vblank_rise) begin
          state_next   = COPY;
          pending_next = 1'b0;
          idx_next     = '0;
        end
      end
      CLEAR: begin
        if (bus.commit_req) pending_next = 1'b1;
        if (idx_last) begin
          idx_next   = '0;
          state_next = pending_next ? ARMED : IDLE;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      COPY: begin
        // A CPU write mid-copy may land behind the copy pointer, so it re-arms the next frame.
        if (bus.cpu_wr || bus.commit_req) pending_next = 1'b1;
        if (bus.clear_req) clear_latch_next = 1'b1;
        if (idx_last) begin
          idx_next = '0;
          if (clear_latch_next) begin
            state_next       = CLEAR;
            clear_latch_next = 1'b0;
          end else begin
            state_next = pending_next ? ARMED : IDLE;
          end
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      pending_q   <= 1'b0;
      clear_latch <= 1'b0;
      vblank_last <= 1'b0;
      committed_q <= 1'b0;
      spr_wr_q    <= 1'b0;
      spr_addr_q  <= '0;
      spr_data_q  <= '0;
      cpu_dout_q  <= '0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      pending_q   <= pending_next;
      clear_latch <= clear_latch_next;
      vblank_last <= bus.vblank;
      spr_wr_q    <= (state == COPY);
      committed_q <= spr_wr_q && (spr_addr_q == LAST_IDX);
      if (state == COPY) begin
        spr_addr_q <= idx;
        spr_data_q <= shadow[idx];
      end
      if (bus.cpu_rd) cpu_dout_q <= shadow[bus.cpu_addr];
    end
  end

  // Single write port: clearing owns it, so CPU writes during CLEAR are dropped.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      shadow[idx] <= 8'h00;
    end else if (bus.cpu_wr) begin
      shadow[bus.cpu_addr] <= bus.cpu_din;
    end
  end

  assign bus.busy              = (state == CLEAR) || (state == COPY) || spr_wr_q;
  assign bus.pending           = pending_q;
  assign bus.committed         = committed_q;
  assign bus.spriteram_wr      = spr_wr_q;
  assign bus.spriteram_wr_addr = spr_addr_q;
  assign bus.spriteram_data_in = spr_data_q;
  assign bus.cpu_dout          = cpu_dout_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader: table-driven CPU access vectors plus
// a scoreboard of expected live-RAM strobes filled from a bench-side shadow model.
module tb_sprite_ram_loader;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [6:0] addr;
    logic [7:0] din;
    logic [7:0] exp_dout;
  } vec_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } strobe_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [7:0] model [128];
  strobe_t    sb_q [$];

  sprite_ram_loader_if #(.ADDR_WIDTH(7)) bus ();

  sprite_ram_loader #(.SPR_COUNT(32), .ITEM_WIDTH(4), .ADDR_WIDTH(7)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every live-RAM strobe must match the next entry the stimulus queued.
  always @(negedge clk) begin
    if (reset && bus.spriteram_wr) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_strobe", 32'(bus.spriteram_wr_addr), 32'hFFFF);
      end else begin
        strobe_t e;
        e = sb_q.pop_front();
        checkOutput("strobe_addr", 32'(bus.spriteram_wr_addr), 32'(e.addr));
        checkOutput("strobe_data", 32'(bus.spriteram_data_in), 32'(e.data));
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic rd, input logic [6:0] addr, input logic [7:0] din);
    bus.cpu_wr   = wr;
    bus.cpu_rd   = rd;
    bus.cpu_addr = addr;
    bus.cpu_din  = din;
    tick();
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
  endtask

  task automatic pushExpect();
    for (int i = 0; i < 128; i++) begin
      strobe_t e;
      e.addr = 7'(i);
      e.data = model[i];
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse(input logic commit, input logic clear);
    bus.commit_req = commit;
    bus.clear_req  = clear;
    tick();
    bus.commit_req = 1'b0;
    bus.clear_req  = 1'b0;
  endtask

  task automatic waitCommit(input string name);
    int seen;
    seen = 0;
    for (int n = 0; n < 300 && seen == 0; n++) begin
      tick();
      if (bus.committed) seen++;
    end
    checkOutput({name, "_committed"}, 32'(seen), 32'd1);
    checkOutput({name, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
    checkOutput({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    tick();
    checkOutput({name, "_committed_one_cycle"}, 32'(bus.committed), 32'd0);
  endtask

  task automatic riseAndCopy(input string name);
    bus.vblank = 1'b0;
    tick();
    pushExpect();
    bus.vblank = 1'b1;
    waitCommit(name);
    bus.vblank = 1'b0;
    tick();
  endtask

  task automatic clearAndCount(input string name, input logic commit, input logic exp_pending);
    int n;
    pulse(commit, 1'b1);
    n = 0;
    while (bus.busy && n < 300) begin
      n++;
      tick();
    end
    checkOutput({name, "_busy_cycles"}, 32'(n), 32'd128);
    checkOutput({name, "_pending"}, 32'(bus.pending), 32'(exp_pending));
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
  endtask

  initial begin
    vec_t vecs [10];
    int   n;
    int   strobes;

    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.vblank = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din = '0;
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
    bus.commit_req = 1'b0;
    bus.clear_req = 1'b0;

    vecs[0] = '{wr: 1'b1, rd: 1'b0, addr: 7'd0, din: 8'h81, exp_dout: 8'h00};
    vecs[1] = '{wr: 1'b1, rd: 1'b0, addr: 7'd1, din: 8'h10, exp_dout: 8'h00};
    vecs[2] = '{wr: 1'b1, rd: 1'b0, addr: 7'd2, din: 8'h23, exp_dout: 8'h00};
    vecs[3] = '{wr: 1'b1, rd: 1'b0, addr: 7'd3, din: 8'h40, exp_dout: 8'h00};
    vecs[4] = '{wr: 1'b0, rd: 1'b1, addr: 7'd2, din: 8'h00, exp_dout: 8'h23};
    vecs[5] = '{wr: 1'b0, rd: 1'b0, addr: 7'd0, din: 8'h00, exp_dout: 8'h23};
    vecs[6] = '{wr: 1'b0, rd: 1'b1, addr: 7'd0, din: 8'h00, exp_dout: 8'h81};
    vecs[7] = '{wr: 1'b1, rd: 1'b1, addr: 7'd3, din: 8'h99, exp_dout: 8'h40};
    vecs[8] = '{wr: 1'b0, rd: 1'b1, addr: 7'd3, din: 8'h00, exp_dout: 8'h99};
    vecs[9] = '{wr: 1'b1, rd: 1'b0, addr: 7'd3, din: 8'h40, exp_dout: 8'h99};

    repeat (3) tick();
    checkOutput("reset_cpu_dout", 32'(bus.cpu_dout), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    checkOutput("reset_pending", 32'(bus.pending), 32'h0);
    checkOutput("reset_committed", 32'(bus.committed), 32'h0);
    checkOutput("reset_spr_wr", 32'(bus.spriteram_wr), 32'h0);
    checkOutput("reset_spr_addr", 32'(bus.spriteram_wr_addr), 32'h0);
    checkOutput("reset_spr_data", 32'(bus.spriteram_data_in), 32'h0);
    reset = 1'b1;
    tick();

    clearAndCount("init_clear", 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
      if (vecs[i].wr) model[vecs[i].addr] = vecs[i].din;
      checkOutput($sformatf("vec%0d_dout", i), 32'(bus.cpu_dout), 32'(vecs[i].exp_dout));
    end

    for (int i = 4; i < 128; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      applyStimulus(1'b1, 1'b0, 7'(i), d);
      model[i] = d;
    end

    // Commit with vblank low arms but does not copy until the rise.
    pulse(1'b1, 1'b0);
    checkOutput("commit_pending", 32'(bus.pending), 32'd1);
    repeat (5) tick();
    checkOutput("commit_still_pending", 32'(bus.pending), 32'd1);
    riseAndCopy("copy1");
    checkOutput("copy1_pending_after", 32'(bus.pending), 32'd0);

    // Clear and commit together: clear first, commit stays armed.
    clearAndCount("clear_commit", 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 7'd77, 8'h00);
    checkOutput("cleared_read", 32'(bus.cpu_dout), 32'h0);
    riseAndCopy("copy_zero");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 7'(i), 8'(8'hA0 + i));
      model[i] = 8'(8'hA0 + i);
    end
    pulse(1'b1, 1'b0);
    bus.vblank = 1'b0;
    tick();
    pushExpect();
    bus.vblank = 1'b1;
    n = 0;
    while (!(bus.spriteram_wr && bus.spriteram_wr_addr == 7'd10) && n < 300) begin
      n++;
      tick();
    end
    checkOutput("midcopy_reached_k10", 32'(n < 300), 32'd1);
    applyStimulus(1'b1, 1'b0, 7'd5, 8'h55);
    model[5] = 8'h55;
    checkOutput("midcopy_write_pending", 32'(bus.pending), 32'd1);
    waitCommit("copy_mid");
    checkOutput("copy_mid_rearmed", 32'(bus.pending), 32'd1);
    bus.vblank = 1'b0;
    tick();
    riseAndCopy("copy_rearm");

    // Commit while vblank is already high must wait for the next rise.
    bus.vblank = 1'b1;
    repeat (3) tick();
    pulse(1'b1, 1'b0);
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.spriteram_wr) strobes++;
    end
    checkOutput("vb_high_no_copy", 32'(strobes), 32'd0);
    checkOutput("vb_high_pending", 32'(bus.pending), 32'd1);
    riseAndCopy("copy_late");

    // Async reset mid-copy aborts immediately.
    pulse(1'b1, 1'b0);
    bus.vblank = 1'b0;
    tick();
    pushExpect();
    bus.vblank = 1'b1;
    n = 0;
    while (!(bus.spriteram_wr && bus.spriteram_wr_addr == 7'd64) && n < 300) begin
      n++;
      tick();
    end
    checkOutput("abort_reached_k64", 32'(n < 300), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_spr_wr", 32'(bus.spriteram_wr), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_pending", 32'(bus.pending), 32'd0);
    sb_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    bus.vblank = 1'b0;
    tick();
    bus.vblank = 1'b1;
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.spriteram_wr || bus.busy) strobes++;
    end
    checkOutput("post_reset_idle", 32'(strobes), 32'd0);
    checkOutput("post_reset_pending", 32'(bus.pending), 32'd0);
    bus.vblank = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
